// File: rtl/grid_game_controller_pkg.sv
// Shared encodings for the grid game engine: cell marks, FSM states, button slots
// and the width helper for the line-scan counter.
package grid_game_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b01,
        CELL_O     = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_PLACE = 4;
    localparam int BTN_NEW   = 5;
    localparam int NUM_BTN   = 6;

    // Bits needed to index the 2N+2 lines (rows, columns, two diagonals)
    function automatic int line_idx_w(input int n);
        return $clog2(2 * n + 2);
    endfunction

endpackage

// File: rtl/grid_game_controller_rise_edge.sv
// Registered rising-edge detector: one-cycle pulse per low-to-high transition of d.
module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev_reg;
    logic rise_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            prev_reg <= d;
            rise_reg <= d & ~prev_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/grid_game_controller.sv
// N x N two-player grid game engine: cursor, board, turn order, win/draw scan,
// plus a registered pixel-to-cell map for the symbol ROMs and rgb mux.
module grid_game_controller
    import grid_game_pkg::*;
#(
    parameter int N        = 3,
    parameter int CELL_W   = 180,
    parameter int CELL_H   = 130,
    parameter int ORIGIN_X = 150,
    parameter int ORIGIN_Y = 34,
    parameter int WIN_LEN  = N
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_place,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    output logic [2:0] cur_row,
    output logic [2:0] cur_col,
    output logic       turn,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw,
    output logic [1:0] pix_cell,
    output logic       pix_cursor,
    output logic       pix_in,
    output logic [7:0] pix_dx,
    output logic [7:0] pix_dy
);

    localparam int CNT_W     = $clog2(N * N + 1);
    localparam int LINE_W    = line_idx_w(N);
    localparam int LAST_LINE = 2 * N + 1;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_rise;

    assign btn_raw = {new_game, btn_place, btn_right, btn_left, btn_down, btn_up};

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_edge
        rise_edge u_edge (
            .clk  (clk),
            .rst  (rst),
            .d    (btn_raw[gi]),
            .rise (btn_rise[gi])
        );
    end

    state_t               state_reg, state_next;
    logic [2*N*N-1:0]     board_reg, board_next;
    logic [2:0]           cur_row_reg, cur_row_next;
    logic [2:0]           cur_col_reg, cur_col_next;
    logic                 turn_reg, turn_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [LINE_W-1:0]    scan_reg, scan_next;
    logic                 over_reg, over_next;
    logic [1:0]           winner_reg, winner_next;
    logic                 draw_reg, draw_next;

    // Line checker: gather the N marks of line scan_reg and test for a full match
    logic [1:0] line_mark [N];
    logic       line_win;

    always_comb begin
        int k;
        int r;
        int c;
        k = int'(scan_reg);
        for (int j = 0; j < N; j++) begin
            if (k < N) begin
                r = k;
                c = j;
            end else if (k < 2 * N) begin
                r = j;
                c = k - N;
            end else if (k == 2 * N) begin
                r = j;
                c = j;
            end else begin
                r = j;
                c = N - 1 - j;
            end
            line_mark[j] = board_reg[2*(r*N+c) +: 2];
        end
        line_win = (line_mark[0] != CELL_EMPTY);
        for (int j = 1; j < WIN_LEN; j++) begin
            if (line_mark[j] != line_mark[0]) begin
                line_win = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_PLAY;
            board_reg   <= '0;
            cur_row_reg <= 3'(N / 2);
            cur_col_reg <= 3'(N / 2);
            turn_reg    <= 1'b0;
            cnt_reg     <= '0;
            scan_reg    <= '0;
            over_reg    <= 1'b0;
            winner_reg  <= CELL_EMPTY;
            draw_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            board_reg   <= board_next;
            cur_row_reg <= cur_row_next;
            cur_col_reg <= cur_col_next;
            turn_reg    <= turn_next;
            cnt_reg     <= cnt_next;
            scan_reg    <= scan_next;
            over_reg    <= over_next;
            winner_reg  <= winner_next;
            draw_reg    <= draw_next;
        end
    end

    always_comb begin
        int cur_idx;
        state_next   = state_reg;
        board_next   = board_reg;
        cur_row_next = cur_row_reg;
        cur_col_next = cur_col_reg;
        turn_next    = turn_reg;
        cnt_next     = cnt_reg;
        scan_next    = scan_reg;
        over_next    = over_reg;
        winner_next  = winner_reg;
        draw_next    = draw_reg;
        cur_idx      = 2 * (int'(cur_row_reg) * N + int'(cur_col_reg));

        case (state_reg)
            ST_PLAY: begin
                // Place outranks every move; an occupied target swallows the press
                if (btn_rise[BTN_PLACE]) begin
                    if (board_reg[cur_idx +: 2] == CELL_EMPTY) begin
                        board_next[cur_idx +: 2] = turn_reg ? CELL_O : CELL_X;
                        cnt_next   = cnt_reg + 1'b1;
                        turn_next  = ~turn_reg;
                        scan_next  = '0;
                        state_next = ST_CHECK;
                    end
                end else if (btn_rise[BTN_RIGHT]) begin
                    cur_col_next = (cur_col_reg == 3'(N - 1)) ? 3'd0 : cur_col_reg + 3'd1;
                end else if (btn_rise[BTN_LEFT]) begin
                    cur_col_next = (cur_col_reg == 3'd0) ? 3'(N - 1) : cur_col_reg - 3'd1;
                end else if (btn_rise[BTN_DOWN]) begin
                    cur_row_next = (cur_row_reg == 3'(N - 1)) ? 3'd0 : cur_row_reg + 3'd1;
                end else if (btn_rise[BTN_UP]) begin
                    cur_row_next = (cur_row_reg == 3'd0) ? 3'(N - 1) : cur_row_reg - 3'd1;
                end
            end
            ST_CHECK: begin
                if (line_win) begin
                    winner_next = line_mark[0];
                    over_next   = 1'b1;
                    state_next  = ST_OVER;
                end else if (scan_reg == LINE_W'(LAST_LINE)) begin
                    if (cnt_reg == CNT_W'(N * N)) begin
                        draw_next  = 1'b1;
                        over_next  = 1'b1;
                        state_next = ST_OVER;
                    end else begin
                        state_next = ST_PLAY;
                    end
                end else begin
                    scan_next = scan_reg + 1'b1;
                end
            end
            ST_OVER: begin
            end
            default: state_next = ST_PLAY;
        endcase

        // A new game preempts everything, including a scan in progress
        if (btn_rise[BTN_NEW]) begin
            state_next   = ST_PLAY;
            board_next   = '0;
            cur_row_next = 3'(N / 2);
            cur_col_next = 3'(N / 2);
            turn_next    = 1'b0;
            cnt_next     = '0;
            scan_next    = '0;
            over_next    = 1'b0;
            winner_next  = CELL_EMPTY;
            draw_next    = 1'b0;
        end
    end

    assign cur_row   = cur_row_reg;
    assign cur_col   = cur_col_reg;
    assign turn      = turn_reg;
    assign game_over = over_reg;
    assign winner    = winner_reg;
    assign draw      = draw_reg;

    // Pixel map: per-boundary comparators, the last one passed gives the cell index
    localparam logic [11:0] X_HI = 12'(ORIGIN_X + N * CELL_W);
    localparam logic [11:0] Y_HI = 12'(ORIGIN_Y + N * CELL_H);

    logic [11:0] h_ext;
    logic [11:0] v_ext;
    logic [N-1:0] col_ge;
    logic [N-1:0] row_ge;
    logic [11:0] col_base [N];
    logic [11:0] row_base [N];

    assign h_ext = {2'b00, hCount};
    assign v_ext = {2'b00, vCount};

    for (genvar gi = 0; gi < N; gi++) begin : g_bound
        localparam logic [11:0] X_LO = 12'(ORIGIN_X + gi * CELL_W);
        localparam logic [11:0] Y_LO = 12'(ORIGIN_Y + gi * CELL_H);
        assign col_ge[gi]   = (h_ext >= X_LO);
        assign row_ge[gi]   = (v_ext >= Y_LO);
        assign col_base[gi] = X_LO;
        assign row_base[gi] = Y_LO;
    end

    logic [2:0]  pcol;
    logic [2:0]  prow;
    logic [11:0] base_x;
    logic [11:0] base_y;
    logic        in_board;

    always_comb begin
        pcol   = 3'd0;
        prow   = 3'd0;
        base_x = col_base[0];
        base_y = row_base[0];
        for (int i = 0; i < N; i++) begin
            if (col_ge[i]) begin
                pcol   = 3'(i);
                base_x = col_base[i];
            end
            if (row_ge[i]) begin
                prow   = 3'(i);
                base_y = row_base[i];
            end
        end
        in_board = col_ge[0] && (h_ext < X_HI) && row_ge[0] && (v_ext < Y_HI);
    end

    logic [1:0] pix_cell_reg;
    logic       pix_cursor_reg;
    logic       pix_in_reg;
    logic [7:0] pix_dx_reg;
    logic [7:0] pix_dy_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cell_reg   <= CELL_EMPTY;
            pix_cursor_reg <= 1'b0;
            pix_in_reg     <= 1'b0;
            pix_dx_reg     <= '0;
            pix_dy_reg     <= '0;
        end else if (in_board) begin
            pix_cell_reg   <= board_reg[2*(int'(prow)*N+int'(pcol)) +: 2];
            pix_cursor_reg <= (prow == cur_row_reg) && (pcol == cur_col_reg);
            pix_in_reg     <= 1'b1;
            pix_dx_reg     <= 8'(h_ext - base_x);
            pix_dy_reg     <= 8'(v_ext - base_y);
        end else begin
            pix_cell_reg   <= CELL_EMPTY;
            pix_cursor_reg <= 1'b0;
            pix_in_reg     <= 1'b0;
            pix_dx_reg     <= '0;
            pix_dy_reg     <= '0;
        end
    end

    assign pix_cell   = pix_cell_reg;
    assign pix_cursor = pix_cursor_reg;
    assign pix_in     = pix_in_reg;
    assign pix_dx     = pix_dx_reg;
    assign pix_dy     = pix_dy_reg;

endmodule

// File: tb/tb_grid_game_controller.sv
// Bench for grid_game_controller: an N=3 and an N=4 instance share the same button
// and pixel stimulus, each compared against an action-level model of the game.
module tb_grid_game_controller;

    localparam int CW = 180;
    localparam int CH = 130;
    localparam int OX = 150;
    localparam int OY = 34;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       new_game, btn_up, btn_down, btn_left, btn_right, btn_place;
    logic [9:0] hCount, vCount;

    logic [2:0] cur_row [2];
    logic [2:0] cur_col [2];
    logic       turn [2];
    logic       game_over [2];
    logic [1:0] winner [2];
    logic       draw [2];
    logic [1:0] pix_cell [2];
    logic       pix_cursor [2];
    logic       pix_in [2];
    logic [7:0] pix_dx [2];
    logic [7:0] pix_dy [2];

    grid_game_controller #(.N(3)) dut3 (
        .clk(clk), .rst(rst), .new_game(new_game),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_place(btn_place),
        .hCount(hCount), .vCount(vCount),
        .cur_row(cur_row[0]), .cur_col(cur_col[0]), .turn(turn[0]),
        .game_over(game_over[0]), .winner(winner[0]), .draw(draw[0]),
        .pix_cell(pix_cell[0]), .pix_cursor(pix_cursor[0]), .pix_in(pix_in[0]),
        .pix_dx(pix_dx[0]), .pix_dy(pix_dy[0])
    );

    grid_game_controller #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .new_game(new_game),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_place(btn_place),
        .hCount(hCount), .vCount(vCount),
        .cur_row(cur_row[1]), .cur_col(cur_col[1]), .turn(turn[1]),
        .game_over(game_over[1]), .winner(winner[1]), .draw(draw[1]),
        .pix_cell(pix_cell[1]), .pix_cursor(pix_cursor[1]), .pix_in(pix_in[1]),
        .pix_dx(pix_dx[1]), .pix_dy(pix_dy[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Action-level model, one slot per instance (0: N=3, 1: N=4)
    int mb [2][8][8];
    int mr [2], mc [2], mturn [2], mcnt [2], mover [2], mwin [2], mdraw [2];

    function automatic int nn(input int m);
        return (m == 0) ? 3 : 4;
    endfunction

    task automatic model_reset(input int m);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mb[m][r][c] = 0;
        mr[m] = nn(m) / 2;
        mc[m] = nn(m) / 2;
        mturn[m] = 0; mcnt[m] = 0; mover[m] = 0; mwin[m] = 0; mdraw[m] = 0;
    endtask

    function automatic int line_owner(input int m);
        int n;
        bit a, b, d1, d2;
        n = nn(m);
        for (int p = 1; p <= 2; p++) begin
            d1 = 1; d2 = 1;
            for (int i = 0; i < n; i++) begin
                a = 1; b = 1;
                for (int j = 0; j < n; j++) begin
                    if (mb[m][i][j] != p) a = 0;
                    if (mb[m][j][i] != p) b = 0;
                end
                if (a || b) return p;
                if (mb[m][i][i] != p) d1 = 0;
                if (mb[m][i][n-1-i] != p) d2 = 0;
            end
            if (d1 || d2) return p;
        end
        return 0;
    endfunction

    // mask bits: 0 up, 1 down, 2 left, 3 right, 4 place, 5 new_game
    task automatic model_action(input int m, input int mask);
        int n, w;
        n = nn(m);
        if ((mask & 32) != 0) begin
            model_reset(m);
            return;
        end
        if (mover[m] != 0) return;
        if ((mask & 16) != 0) begin
            if (mb[m][mr[m]][mc[m]] == 0) begin
                mb[m][mr[m]][mc[m]] = mturn[m] + 1;
                mcnt[m]++;
                mturn[m] ^= 1;
                w = line_owner(m);
                if (w != 0) begin
                    mover[m] = 1; mwin[m] = w;
                end else if (mcnt[m] == n * n) begin
                    mover[m] = 1; mdraw[m] = 1;
                end
            end
        end else if ((mask & 8) != 0) mc[m] = (mc[m] + 1) % n;
        else if ((mask & 4) != 0) mc[m] = (mc[m] + n - 1) % n;
        else if ((mask & 2) != 0) mr[m] = (mr[m] + 1) % n;
        else if ((mask & 1) != 0) mr[m] = (mr[m] + n - 1) % n;
    endtask

    task automatic check_state();
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("n%0d_cur_row", nn(m)), cur_row[m], mr[m]);
            check_eq($sformatf("n%0d_cur_col", nn(m)), cur_col[m], mc[m]);
            check_eq($sformatf("n%0d_turn", nn(m)), turn[m], mturn[m]);
            check_eq($sformatf("n%0d_game_over", nn(m)), game_over[m], mover[m]);
            check_eq($sformatf("n%0d_winner", nn(m)), winner[m], mwin[m]);
            check_eq($sformatf("n%0d_draw", nn(m)), draw[m], mdraw[m]);
        end
    endtask

    task automatic drive(input int mask, input int hold);
        {new_game, btn_place, btn_right, btn_left, btn_down, btn_up} = 6'(mask);
        repeat (hold) @(negedge clk);
        {new_game, btn_place, btn_right, btn_left, btn_down, btn_up} = 6'd0;
    endtask

    task automatic press_gap(input int mask, input int gap);
        drive(mask, $urandom_range(1, 3));
        repeat (gap) @(negedge clk);
        model_action(0, mask);
        model_action(1, mask);
        $display("press mask=%02h n3:(%0d,%0d) t=%0d ov=%0d  n4:(%0d,%0d) t=%0d ov=%0d",
                 mask, mr[0], mc[0], mturn[0], mover[0], mr[1], mc[1], mturn[1], mover[1]);
        check_state();
    endtask

    task automatic press(input int mask);
        press_gap(mask, ((mask & 16) != 0) ? 14 : 2);
    endtask

    task automatic goto(input int m, input int r, input int c);
        for (int i = 0; i < 10 && mr[m] != r; i++) press(2);
        for (int i = 0; i < 10 && mc[m] != c; i++) press(8);
    endtask

    task automatic check_pix(input int h, input int v);
        int n, x, y, e_in, e_cell, e_cur, e_dx, e_dy;
        hCount = 10'(h);
        vCount = 10'(v);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n = nn(m);
            e_in = (h >= OX && h < OX + n * CW && v >= OY && v < OY + n * CH) ? 1 : 0;
            e_cell = 0; e_cur = 0; e_dx = 0; e_dy = 0;
            if (e_in != 0) begin
                x = h - OX; y = v - OY;
                e_dx = x % CW; e_dy = y % CH;
                e_cell = mb[m][y / CH][x / CW];
                e_cur = ((y / CH) == mr[m] && (x / CW) == mc[m]) ? 1 : 0;
            end
            check_eq($sformatf("n%0d_pix_in@%0d,%0d", n, h, v), pix_in[m], e_in);
            check_eq($sformatf("n%0d_pix_cell@%0d,%0d", n, h, v), pix_cell[m], e_cell);
            check_eq($sformatf("n%0d_pix_cursor@%0d,%0d", n, h, v), pix_cursor[m], e_cur);
            check_eq($sformatf("n%0d_pix_dx@%0d,%0d", n, h, v), pix_dx[m], e_dx);
            check_eq($sformatf("n%0d_pix_dy@%0d,%0d", n, h, v), pix_dy[m], e_dy);
        end
    endtask

    task automatic check_board();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                check_pix(OX + c * CW + $urandom_range(0, CW - 1),
                          OY + r * CH + $urandom_range(0, CH - 1));
    endtask

    int draw_seq [9][2] = '{'{0,0},'{0,1},'{0,2},'{1,1},'{1,0},'{2,0},'{2,1},'{1,2},'{2,2}};
    int diag_seq [7][2] = '{'{0,0},'{0,1},'{1,1},'{0,2},'{2,2},'{0,3},'{3,3}};

    initial begin
        int lat, r, mask;
        rst = 1'b1;
        {new_game, btn_place, btn_right, btn_left, btn_down, btn_up} = 6'd0;
        hCount = '0;
        vCount = '0;
        model_reset(0);
        model_reset(1);
        repeat (3) @(negedge clk);
        check_state();
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("n%0d_rst_pix_in", nn(m)), pix_in[m], 0);
            check_eq($sformatf("n%0d_rst_pix_dx", nn(m)), pix_dx[m], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Cursor wrap at right and top edges
        press(8);
        press(8);
        check_eq("t1_wrap_col", cur_col[0], 0);
        press(1);
        press(1);
        check_eq("t1_wrap_row", cur_row[0], 2);

        // X wins along row 0
        press(32);
        goto(0, 0, 0); press(16);
        goto(0, 1, 1); press(16);
        goto(0, 0, 1); press(16);
        goto(0, 2, 2); press(16);
        goto(0, 0, 2);
        btn_place = 1'b1;
        lat = 0;
        while (game_over[0] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) btn_place = 1'b0;
        end
        btn_place = 1'b0;
        check_eq("t2_win_latency_ok", (lat <= 2 * 3 + 4) ? 1 : 0, 1);
        repeat (14) @(negedge clk);
        model_action(0, 16);
        model_action(1, 16);
        check_state();
        check_eq("t2_winner", winner[0], 1);
        check_board();

        // Occupied cell: no turn change, and no scan blocks an immediate move
        press(32);
        goto(0, 1, 1);
        press(16);
        press_gap(16, 3);
        press_gap(8, 2);
        check_eq("t3_turn", turn[0], 1);
        check_board();

        // Full-board draw, then further input ignored
        press(32);
        for (int i = 0; i < 9; i++) begin
            goto(0, draw_seq[i][0], draw_seq[i][1]);
            press(16);
        end
        check_eq("t4_draw", draw[0], 1);
        check_eq("t4_winner", winner[0], 0);
        press(16);
        press(8);
        check_board();

        // new_game while a scan is in flight
        press(32);
        goto(0, 0, 0);
        press_gap(16, 2);
        drive(32, 1);
        @(negedge clk);
        model_action(0, 32);
        model_action(1, 32);
        check_state();
        check_board();

        // N=4 main-diagonal win for X
        for (int i = 0; i < 7; i++) begin
            goto(1, diag_seq[i][0], diag_seq[i][1]);
            press(16);
        end
        check_eq("t5_n4_winner", winner[1], 1);
        check_eq("t5_n4_over", game_over[1], 1);
        check_board();

        // Pixel offsets in cell (0,1)
        press(32);
        goto(0, 0, 1);
        press(16);
        check_pix(OX + CW + 5, OY + 3);
        check_eq("t6_pix_in", pix_in[0], 1);
        check_eq("t6_pix_dx", pix_dx[0], 5);
        check_eq("t6_pix_dy", pix_dy[0], 3);
        check_eq("t6_pix_cell", pix_cell[0], 1);

        // Randomized play including simultaneous presses
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4) mask = 32;
            else if (r < 22) mask = $urandom_range(1, 31);
            else mask = 1 << $urandom_range(0, 4);
            if (mover[0] != 0 && mover[1] != 0 && r < 50) mask = 32;
            press(mask);
            if (i % 8 == 0)
                check_pix($urandom_range(100, 1000), $urandom_range(0, 620));
            if (i % 50 == 49)
                check_board();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
